// File: rtl/sweep_controller_if.sv
// Configuration and live-frequency bundle between the config logic,
// the sweep controller and the phase-accumulator frequency register.
interface sweep_controller_if;
   logic [19:0] freq_base;
   logic [16:0] sweep_range;
   logic [12:0] sweep_speed;
   logic [1:0]  sweep_mode;
   logic        sweep_hold;
   logic [19:0] freq_out;
   logic        freq_load;
   logic        sweep_active;
   logic        sweep_dir;

   modport master (
      output freq_base, sweep_range, sweep_speed, sweep_mode, sweep_hold,
      input  freq_out, freq_load, sweep_active, sweep_dir
   );

   modport slave (
      input  freq_base, sweep_range, sweep_speed, sweep_mode, sweep_hold,
      output freq_out, freq_load, sweep_active, sweep_dir
   );
endinterface

// File: rtl/sweep_controller.sv
// Frequency sweep sequencer: 1 ms time base, up/down/triangle stepping of the
// live frequency between freq_base and min(freq_base + sweep_range, FMAX).
module sweep_controller #(
   parameter int unsigned TICK_CYCLES  = 100000,
   parameter int unsigned FMAX         = 999000,
   parameter int unsigned DEFAULT_FREQ = 100000
) (
   input  logic              clk,
   input  logic              rst,
   sweep_controller_if.slave bus
);
   localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
   localparam logic [20:0]   FMAX_W    = 21'(FMAX);

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [19:0]   freq_q, freq_d;
   logic          load_q, load_d;
   logic          dir_q, dir_d;
   logic [1:0]    mode_q;
   logic [19:0]   base_q;
   logic [16:0]   range_q;

   logic [20:0] lo, sum, hi, cur, spd, up, dn, lo_s;
   logic [19:0] nxt;
   logic        nxt_dir;
   logic        restart;

   // All bound arithmetic at 21 bits so base + range and cur + speed never wrap
   always_comb begin
      lo   = {1'b0, bus.freq_base};
      sum  = lo + {4'b0, bus.sweep_range};
      hi   = (sum > FMAX_W) ? FMAX_W : sum;
      cur  = {1'b0, freq_q};
      spd  = {8'b0, bus.sweep_speed};
      up   = cur + spd;
      dn   = cur - spd;
      lo_s = lo + spd;
   end

   always_comb begin
      nxt     = freq_q;
      nxt_dir = dir_q;
      case (bus.sweep_mode)
         2'd1: nxt = (up > hi) ? lo[19:0] : up[19:0];
         2'd2: nxt = (cur < lo_s) ? hi[19:0] : dn[19:0];
         2'd3: begin
            if (!dir_q) begin
               if (up >= hi) begin
                  nxt     = hi[19:0];
                  nxt_dir = 1'b1;
               end else nxt = up[19:0];
            end else begin
               if (cur <= lo_s) begin
                  nxt     = lo[19:0];
                  nxt_dir = 1'b0;
               end else nxt = dn[19:0];
            end
         end
         default: ;
      endcase
   end

   assign restart = (bus.sweep_mode != mode_q) || (bus.freq_base != base_q) ||
                    (bus.sweep_range != range_q);

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      freq_d  = freq_q;
      load_d  = 1'b0;
      dir_d   = dir_q;
      case (state_q)
         IDLE: begin
            tick_d = '0;
            dir_d  = 1'b0;
            // Skip tracking when about to enter LOAD, avoiding a spurious pulse
            if (!(restart && bus.sweep_mode != 2'd0) && bus.freq_base != freq_q) begin
               freq_d = bus.freq_base;
               load_d = 1'b1;
            end
         end
         LOAD: begin
            tick_d  = '0;
            dir_d   = 1'b0;
            freq_d  = (bus.sweep_mode == 2'd2) ? hi[19:0] : lo[19:0];
            load_d  = 1'b1;
            state_d = RUN;
         end
         RUN: begin
            if (!bus.sweep_hold) begin
               if (tick_q == TICK_LAST) begin
                  tick_d = '0;
                  freq_d = nxt;
                  dir_d  = nxt_dir;
                  load_d = 1'b1;
               end else tick_d = tick_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (restart) begin
         state_d = (bus.sweep_mode != 2'd0) ? LOAD : IDLE;
         if (state_q == RUN) begin
            tick_d = '0;
            freq_d = freq_q;
            dir_d  = dir_q;
            load_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         tick_q  <= '0;
         freq_q  <= 20'(DEFAULT_FREQ);
         load_q  <= 1'b0;
         dir_q   <= 1'b0;
         mode_q  <= '0;
         base_q  <= '0;
         range_q <= '0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         freq_q  <= freq_d;
         load_q  <= load_d;
         dir_q   <= dir_d;
         mode_q  <= bus.sweep_mode;
         base_q  <= bus.freq_base;
         range_q <= bus.sweep_range;
      end
   end

   assign bus.freq_out     = freq_q;
   assign bus.freq_load    = load_q;
   assign bus.sweep_active = (state_q == RUN);
   assign bus.sweep_dir    = dir_q;
endmodule

// File: tb/tb_sweep_controller.sv
// Directed bench for sweep_controller with a 10-cycle time base.
module tb_sweep_controller;
   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   sweep_controller_if bus();

   sweep_controller #(.TICK_CYCLES(10), .FMAX(999000), .DEFAULT_FREQ(100000)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Cycles until the next freq_load pulse, -1 if none within max
   task automatic wait_load(input int max, output int n);
      n = -1;
      for (int i = 1; i <= max; i++) begin
         cyc(1);
         if (bus.freq_load === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic set_cfg(input int base, input int range, input int speed, input int mode);
      bus.freq_base   = 20'(base);
      bus.sweep_range = 17'(range);
      bus.sweep_speed = 13'(speed);
      bus.sweep_mode  = 2'(mode);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.sweep_hold = 1'b0;
      set_cfg(100000, 0, 0, 0);
      cyc(2);
      checks++; if (bus.freq_out !== 20'd100000) begin errors++; $display("FAIL reset_freq: got %0d want 100000", bus.freq_out); end
      checks++; if (bus.freq_load !== 1'b0) begin errors++; $display("FAIL reset_load: got %b want 0", bus.freq_load); end
      checks++; if (bus.sweep_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", bus.sweep_active); end
      checks++; if (bus.sweep_dir !== 1'b0) begin errors++; $display("FAIL reset_dir: got %b want 0", bus.sweep_dir); end
      rst = 1'b0;
      cyc(3);
      checks++; if (bus.freq_out !== 20'd100000 || bus.freq_load !== 1'b0) begin
         errors++; $display("FAIL post_reset_idle: got %0d/%b want 100000/0", bus.freq_out, bus.freq_load); end
   endtask

   task automatic test_idle;
      int loads;
      bus.freq_base = 20'd250000;
      cyc(1);
      checks++; if (bus.freq_out !== 20'd250000) begin errors++; $display("FAIL idle_follow: got %0d want 250000", bus.freq_out); end
      loads = int'(bus.freq_load);
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         loads += int'(bus.freq_load);
      end
      checks++; if (loads !== 1) begin errors++; $display("FAIL idle_pulses: got %0d want 1", loads); end
      checks++; if (bus.sweep_active !== 1'b0) begin errors++; $display("FAIL idle_active: got %b want 0", bus.sweep_active); end
   endtask

   task automatic test_up_ramp;
      int n;
      int exp_f[3];
      exp_f = '{102000, 104000, 100000};
      set_cfg(100000, 5000, 2000, 1);
      wait_load(20, n);
      checks++; if (n !== 2 || bus.freq_out !== 20'd100000) begin
         errors++; $display("FAIL up_load: got lat %0d freq %0d want 2/100000", n, bus.freq_out); end
      checks++; if (bus.sweep_active !== 1'b1) begin errors++; $display("FAIL up_active: got %b want 1", bus.sweep_active); end
      for (int i = 0; i < 3; i++) begin
         wait_load(20, n);
         checks++; if (n !== 10 || bus.freq_out !== 20'(exp_f[i])) begin
            errors++; $display("FAIL up_step%0d: got lat %0d freq %0d want 10/%0d", i, n, bus.freq_out, exp_f[i]); end
      end
   endtask

   task automatic test_triangle;
      int n;
      int exp_f[7];
      logic exp_d[7];
      exp_f = '{102000, 104000, 105000, 103000, 101000, 100000, 102000};
      exp_d = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      bus.sweep_mode = 2'd3;
      wait_load(20, n);
      checks++; if (n !== 2 || bus.freq_out !== 20'd100000 || bus.sweep_dir !== 1'b0) begin
         errors++; $display("FAIL tri_load: got lat %0d freq %0d dir %b want 2/100000/0", n, bus.freq_out, bus.sweep_dir); end
      for (int i = 0; i < 7; i++) begin
         wait_load(20, n);
         checks++; if (n !== 10 || bus.freq_out !== 20'(exp_f[i]) || bus.sweep_dir !== exp_d[i]) begin
            errors++; $display("FAIL tri_step%0d: got lat %0d freq %0d dir %b want 10/%0d/%b",
                               i, n, bus.freq_out, bus.sweep_dir, exp_f[i], exp_d[i]); end
      end
   endtask

   task automatic test_down_clamp;
      int n;
      int exp_f[3];
      exp_f = '{998000, 999000, 998000};
      set_cfg(998000, 20000, 1000, 2);
      wait_load(20, n);
      checks++; if (n !== 2 || bus.freq_out !== 20'd999000) begin
         errors++; $display("FAIL down_load: got lat %0d freq %0d want 2/999000", n, bus.freq_out); end
      for (int i = 0; i < 3; i++) begin
         wait_load(20, n);
         checks++; if (n !== 10 || bus.freq_out !== 20'(exp_f[i])) begin
            errors++; $display("FAIL down_step%0d: got lat %0d freq %0d want 10/%0d", i, n, bus.freq_out, exp_f[i]); end
      end
   endtask

   task automatic test_zero_range;
      int n;
      set_cfg(300000, 0, 2000, 1);
      wait_load(20, n);
      checks++; if (n !== 2 || bus.freq_out !== 20'd300000) begin
         errors++; $display("FAIL zr_load: got lat %0d freq %0d want 2/300000", n, bus.freq_out); end
      wait_load(20, n);
      checks++; if (n !== 10 || bus.freq_out !== 20'd300000) begin
         errors++; $display("FAIL zr_step: got lat %0d freq %0d want 10/300000", n, bus.freq_out); end
   endtask

   task automatic test_restart_hold;
      int n;
      int loads;
      set_cfg(100000, 5000, 2000, 1);
      wait_load(20, n);
      wait_load(20, n);
      wait_load(20, n);
      checks++; if (bus.freq_out !== 20'd104000) begin errors++; $display("FAIL rs_pre: got %0d want 104000", bus.freq_out); end
      loads = 0;
      for (int i = 0; i < 9; i++) begin
         cyc(1);
         loads += int'(bus.freq_load);
      end
      bus.freq_base = 20'd200000;
      cyc(1);
      checks++; if (loads !== 0 || bus.freq_load !== 1'b0 || bus.freq_out !== 20'd104000) begin
         errors++; $display("FAIL rs_step_blocked: got loads %0d load %b freq %0d want 0/0/104000", loads, bus.freq_load, bus.freq_out); end
      cyc(1);
      checks++; if (bus.freq_load !== 1'b1 || bus.freq_out !== 20'd200000) begin
         errors++; $display("FAIL rs_load: got load %b freq %0d want 1/200000", bus.freq_load, bus.freq_out); end
      wait_load(20, n);
      checks++; if (n !== 10 || bus.freq_out !== 20'd202000) begin
         errors++; $display("FAIL rs_step: got lat %0d freq %0d want 10/202000", n, bus.freq_out); end
      bus.sweep_hold = 1'b1;
      loads = 0;
      for (int i = 0; i < 35; i++) begin
         cyc(1);
         loads += int'(bus.freq_load);
      end
      checks++; if (loads !== 0 || bus.freq_out !== 20'd202000) begin
         errors++; $display("FAIL hold: got loads %0d freq %0d want 0/202000", loads, bus.freq_out); end
      bus.sweep_hold = 1'b0;
      wait_load(20, n);
      checks++; if (n !== 10 || bus.freq_out !== 20'd204000) begin
         errors++; $display("FAIL hold_resume: got lat %0d freq %0d want 10/204000", n, bus.freq_out); end
      bus.sweep_speed = 13'd500;
      wait_load(20, n);
      checks++; if (n !== 10 || bus.freq_out !== 20'd204500) begin
         errors++; $display("FAIL speed_change: got lat %0d freq %0d want 10/204500", n, bus.freq_out); end
   endtask

   task automatic test_reset_mid;
      int n;
      set_cfg(100000, 5000, 2000, 3);
      wait_load(20, n);
      wait_load(20, n);
      wait_load(20, n);
      wait_load(20, n);
      checks++; if (bus.freq_out !== 20'd105000 || bus.sweep_dir !== 1'b1) begin
         errors++; $display("FAIL rm_pre: got freq %0d dir %b want 105000/1", bus.freq_out, bus.sweep_dir); end
      cyc(3);
      rst = 1'b1;
      #1;
      checks++; if (bus.freq_out !== 20'd100000 || bus.freq_load !== 1'b0 ||
                    bus.sweep_active !== 1'b0 || bus.sweep_dir !== 1'b0) begin
         errors++; $display("FAIL rm_async: got freq %0d load %b act %b dir %b want 100000/0/0/0",
                            bus.freq_out, bus.freq_load, bus.sweep_active, bus.sweep_dir); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      wait_load(20, n);
      checks++; if (n !== 2 || bus.freq_out !== 20'd100000 || bus.sweep_active !== 1'b1 || bus.sweep_dir !== 1'b0) begin
         errors++; $display("FAIL rm_reload: got lat %0d freq %0d act %b dir %b want 2/100000/1/0",
                            n, bus.freq_out, bus.sweep_active, bus.sweep_dir); end
      wait_load(20, n);
      checks++; if (n !== 10 || bus.freq_out !== 20'd102000) begin
         errors++; $display("FAIL rm_step: got lat %0d freq %0d want 10/102000", n, bus.freq_out); end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_up_ramp();
      test_triangle();
      test_down_clamp();
      test_zero_range();
      test_restart_hold();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sweep_controller.md
Name: sweep_controller

Overview:
Sequences the output frequency of the waveform datapath from the operator configuration: base frequency, sweep range (Hz), sweep speed (Hz/ms) and sweep mode. Generates a 1 ms time base and steps the live frequency once per ms as an up-ramp, a down-ramp or a triangle between the sweep bounds. Sits between the input configuration logic and the phase-accumulator frequency register. Presents each new value with a one-cycle load strobe.

Parameters:
TICK_CYCLES, 100000, clk cycles per 1 ms step (100 MHz clk); the bench overrides it.
FMAX, 999000, upper clamp for the sweep top, in Hz.
DEFAULT_FREQ, 100000, freq_out value at reset, in Hz.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
freq_base  in  20  base frequency in Hz (1000..999000)
sweep_range  in  17  sweep span in Hz (0..50000)
sweep_speed  in  13  step per ms in Hz (0..4000)
sweep_mode  in  2  0 = off, 1 = up-ramp, 2 = down-ramp, 3 = triangle
sweep_hold  in  1  freezes the sweep while high
freq_out  out  20  live frequency to the datapath, in Hz
freq_load  out  1  one-cycle pulse, high in the same cycle freq_out takes a new value
sweep_active  out  1  high while in RUN state
sweep_dir  out  1  triangle direction: 0 = up, 1 = down

Behaviour:
- Reset and clocking: one clock, clk; reset is asynchronous and active-high on rst. Reset values: freq_out = DEFAULT_FREQ, freq_load = 0, sweep_active = 0, sweep_dir = 0, state = IDLE, tick counter = 0. The registered configuration copies reset to 0 / mode 0.
- Bounds: lo = freq_base. hi = min(freq_base + sweep_range, FMAX). The sum is computed at 21 bits, so it cannot overflow.
- Tick counter: counts 0..TICK_CYCLES-1 in RUN only. At the terminal count it produces a step and wraps to 0. It is cleared in IDLE and LOAD and held while sweep_hold = 1.
- States:
  - IDLE (mode 0): freq_out <= freq_base with 1-cycle latency. freq_load pulses only on cycles where freq_out changes. sweep_dir = 0.
  - LOAD (exactly 1 cycle): freq_out <= start value and freq_load = 1. Start value is hi for mode 2, lo for modes 1 and 3. sweep_dir <= 0. Next state is RUN.
  - RUN: on each step, when sweep_hold = 0, apply the mode rule below with s = sweep_speed. freq_load = 1 on every step, even when the value is unchanged.
- Mode rules in RUN:
  - Up-ramp: if cur + s > hi then cur <= lo, else cur <= cur + s.
  - Down-ramp: if cur < lo + s then cur <= hi, else cur <= cur - s.
  - Triangle, dir up: if cur + s >= hi then cur <= hi and dir <= 1, else cur <= cur + s.
  - Triangle, dir down: if cur <= lo + s then cur <= lo and dir <= 0, else cur <= cur - s.
- Restart: a change of sweep_mode, freq_base or sweep_range is detected against the registered copies.
  - Nonzero new mode: go to LOAD on the next cycle.
  - New mode 0: go to IDLE.
  - A restart takes priority over a simultaneous step.
- sweep_speed changes never restart the sweep; the new value applies at the next step.
- Degenerate cases: s = 0 or sweep_range = 0 keeps freq_out constant, but freq_load still pulses each step. All arithmetic stays at 21 bits, so hi is never exceeded and the result never drops below lo.
- Hold: releasing sweep_hold resumes the tick count from its frozen value.
- Reset mid-sweep: all outputs return to their reset values immediately (asynchronous). After rst deasserts, the block goes to IDLE, or to LOAD if the mode inputs are nonzero, via the restart detect.

Test Plan:
1. Mode 0, freq_base 100000 -> 250000: freq_out = 250000 one cycle later; exactly one freq_load pulse; sweep_active = 0.
2. Up-ramp, TICK_CYCLES = 10, base 100000, range 5000, speed 2000: LOAD gives 100000; steps every 10 cycles give 102000, 104000, then wrap to 100000.
3. Triangle, same config: 100000, 102000, 104000, 105000 (dir -> 1), 103000, 101000, 100000 (dir -> 0), 102000.
4. Down-ramp, base 998000, range 20000, speed 1000: hi clamps to 999000; sequence 999000, 998000, 999000, 998000.
5. Up-ramp at 104000: change base to 200000 in the cycle before a step. LOAD wins, freq_out = 200000, and the next step comes exactly 10 cycles later. Repeat with sweep_hold = 1 for 35 cycles: no steps and no freq_load.
6. Assert rst for 1 cycle mid-triangle: freq_out = 100000, all flags 0 immediately; after release, LOAD restarts the sweep at lo.
